// File: rtl/fulladder.sv
// ---------------------------------------------------------------------------
// fulladder: registered ripple-carry adder. It is built from per-bit
// full-adder cells, and WIDTH=1 gives the classic single-bit cell.
//
// Parameters
//   WIDTH      operand and sum width in bits (1..64)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   A/B/C are captured on this edge
//   A, B       unsigned operands, WIDTH bits
//   C          carry-in
//   S          registered sum, WIDTH bits
//   Ca         registered carry-out
//   out_valid  S/Ca hold a result captured on the previous edge
//   ovf        registered two's-complement overflow
//              (present only when FULLADDER_OVF_EN is defined)
//
// Optional feature macro: FULLADDER_OVF_EN
//
// Handshake: this block has no ready signal and never stalls.
//   - When in_valid is high at a rising edge, A/B/C are summed and
//     registered on that edge.
//   - out_valid is high for exactly one cycle per captured result.
//   - When in_valid is low at an edge, S/Ca/ovf hold their values and
//     out_valid drops.
// ---------------------------------------------------------------------------
module fulladder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic [WIDTH-1:0] S,
  output logic             Ca,
`ifdef FULLADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  // carry[i] is the carry into bit i. carry[WIDTH] is the word carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;

  assign carry[0] = C;

  // The ripple chain through these cells is the critical path.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic half_sum;
    assign half_sum    = A[i] ^ B[i];
    assign sum_bits[i] = half_sum ^ carry[i];
    assign carry[i+1]  = (A[i] & B[i]) | (carry[i] & half_sum);
  end

`ifdef FULLADDER_OVF_EN
  // Signed overflow is flagged when the carry into the MSB differs from the
  // carry out of it. For WIDTH=1 the carry into the MSB is C itself.
  logic ovf_next;
  assign ovf_next = carry[WIDTH] ^ carry[WIDTH-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S         <= '0;
      Ca        <= 1'b0;
      out_valid <= 1'b0;
`ifdef FULLADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S   <= sum_bits;
        Ca  <= carry[WIDTH];
`ifdef FULLADDER_OVF_EN
        ovf <= ovf_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fulladder.sv
// ---------------------------------------------------------------------------
// tb_fulladder: bench for fulladder. It drives two instances side by side,
// one with WIDTH=1 and one with WIDTH=8. An arithmetic reference model
// fills one expected queue per instance. A negedge compare process checks
// every cycle against those queues. Directed literal checks in the main
// sequence confirm that the model itself is correct.
// ---------------------------------------------------------------------------
module tb_fulladder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic       iv1, a1, b1, c1, s1, ca1, ov1;
  logic       iv8, c8, ca8, ov8;
  logic [7:0] a8, b8, s8;
`ifdef FULLADDER_OVF_EN
  logic       f1, f8;
`endif

  fulladder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .A(a1), .B(b1), .C(c1),
    .S(s1), .Ca(ca1),
`ifdef FULLADDER_OVF_EN
    .ovf(f1),
`endif
    .out_valid(ov1)
  );

  fulladder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .A(a8), .B(b8), .C(c8),
    .S(s8), .Ca(ca8),
`ifdef FULLADDER_OVF_EN
    .ovf(f8),
`endif
    .out_valid(ov8)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // Each entry is packed as {ovf, carry_out, sum[7:0]}.
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q8[$];
  logic [9:0] h1 = '0, h8 = '0;  // value the outputs should currently hold
  logic       v1m = 1'b0, v8m = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned sum at w+1 bits. Overflow is judged from the
  // signed range of a w-bit result.
  function automatic logic [9:0] ref_add(input int w, input int a, input int b, input int c);
    longint us, sa, sb, ss, lim;
    logic [9:0] r;
    us  = longint'(a) + longint'(b) + longint'(c);
    lim = longint'(1) << (w - 1);
    sa  = (a >= lim) ? a - 2 * lim : a;
    sb  = (b >= lim) ? b - 2 * lim : b;
    ss  = sa + sb + c;
    r      = '0;
    r[7:0] = 8'(us % (2 * lim));
    r[8]   = (us >= 2 * lim);
    r[9]   = (ss > lim - 1) || (ss < -lim);
    return r;
  endfunction

  // Model: samples the inputs on every rising edge.
  initial forever begin
    @(posedge clk);
    if (rst !== 1'b0) begin
      v1m = 1'b0;
      v8m = 1'b0;
    end else begin
      v1m = iv1;
      v8m = iv8;
      if (iv1) exp_q1.push_back(ref_add(1, int'(a1), int'(b1), int'(c1)));
      if (iv8) exp_q8.push_back(ref_add(8, int'(a8), int'(b8), int'(c8)));
    end
  end

  // Asynchronous reset discards everything that is in flight.
  initial forever begin
    @(posedge rst);
    exp_q1.delete();
    exp_q8.delete();
    h1  = '0;
    h8  = '0;
    v1m = 1'b0;
    v8m = 1'b0;
  end

  // Compare process: runs on every falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_w1_s",  s1,  '0);
      check("rst_w1_ca", ca1, '0);
      check("rst_w1_ov", ov1, '0);
      check("rst_w8_s",  s8,  '0);
      check("rst_w8_ca", ca8, '0);
      check("rst_w8_ov", ov8, '0);
    end else begin
      check("w1_out_valid", ov1, v1m);
      if (v1m) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL w1_queue: got empty queue, expected an entry at %0t", $time);
        end else h1 = exp_q1.pop_front();
      end
      check("w1_sum",   s1,  h1[0]);
      check("w1_carry", ca1, h1[8]);
      check("w8_out_valid", ov8, v8m);
      if (v8m) begin
        if (exp_q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL w8_queue: got empty queue, expected an entry at %0t", $time);
        end else h8 = exp_q8.pop_front();
      end
      check("w8_sum",   s8,  h8[7:0]);
      check("w8_carry", ca8, h8[8]);
`ifdef FULLADDER_OVF_EN
      check("w1_ovf", f1, h1[9]);
      check("w8_ovf", f8, h8[9]);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic a, input logic b, input logic c, input logic v);
    a1 = a; b1 = b; c1 = c; iv1 = v;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    a8 = a; b8 = b; c8 = c; iv8 = v;
  endtask

  // ---------------- directed sequence ----------------
  logic [1:0] lit1 [8];
  logic [2:0] vec;

  initial begin
    lit1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b1;
    drive1(0, 0, 0, 0);
    drive8(8'h00, 8'h00, 0, 0);
    repeat (2) tick();
    check("reset_s8",  s8,  '0);
    check("reset_ov8", ov8, '0);
    rst = 1'b0;

    // WIDTH=1, all eight input combinations back to back
    for (int k = 0; k < 8; k++) begin
      vec = 3'(k);
      drive1(vec[2], vec[1], vec[0], 1'b1);
      tick();
      check("w1_exhaustive", {ca1, s1}, lit1[k]);
      check("w1_exh_valid", ov1, 1'b1);
    end

    // Hold: outputs keep 1+1+0 once in_valid drops
    drive1(1, 1, 0, 1);
    tick();
    check("hold_capture", {ca1, s1}, 2'b10);
    drive1(0, 0, 0, 0);
    tick();
    check("hold_value", {ca1, s1}, 2'b10);
    check("hold_valid", ov1, 1'b0);
    tick();
    check("hold_value2", {ca1, s1}, 2'b10);

    // Reset must take effect immediately, before the next clock edge
    drive1(1, 1, 1, 1);
    tick();
    check("pre_rst", {ca1, s1}, 2'b11);
    drive1(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_s",  {ca1, s1}, 2'b00);
    check("async_rst_ov", ov1, 1'b0);
    tick();
    rst = 1'b0;

    // Reset arriving between a capture and the next edge
    drive1(1, 1, 1, 1);
    tick();
    drive1(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    check("inflight_s",  {ca1, s1}, 2'b00);
    check("inflight_ov", ov1, 1'b0);
    tick();
    check("inflight_s2", {ca1, s1}, 2'b00);
    drive1(0, 1, 1, 1);
    tick();
    check("post_rst_new", {ca1, s1}, 2'b10);
    check("post_rst_ov",  ov1, 1'b1);
    drive1(0, 0, 0, 0);

    // WIDTH=8 boundary values
    drive8(8'hFF, 8'hFF, 1, 1);
    tick();
    check("w8_max", {ca8, s8}, 9'h1FF);
    drive8(8'h80, 8'h80, 0, 1);
    tick();
    check("w8_min_neg", {ca8, s8}, 9'h100);
`ifdef FULLADDER_OVF_EN
    check("w8_min_neg_ovf", f8, 1'b1);
`endif
    drive8(8'h00, 8'h00, 0, 1);
    tick();
    check("w8_zero", {ca8, s8}, 9'h000);
    drive8(8'h7F, 8'h01, 0, 1);
    tick();
    check("w8_pos_ovf", {ca8, s8}, 9'h080);
`ifdef FULLADDER_OVF_EN
    check("w8_pos_ovf_flag", f8, 1'b1);
`endif

    // Random traffic on both instances; the compare process checks each cycle
    repeat (1000) begin
      drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    drive1(0, 0, 0, 0);
    drive8(8'h00, 8'h00, 0, 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fulladder.md
Name: fulladder

Overview:
- Registered full adder.
- Sums operand A, operand B and carry-in C, and presents sum S and carry-out Ca one clock after capture.
- Default width is 1 bit, which gives the classic single-bit full-adder cell.
- WIDTH > 1 gives a ripple-carry word adder built from per-bit full-adder cells. It is used as a leaf arithmetic primitive in datapaths.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  A/B/C are valid and are captured this edge.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- C  input  1  carry-in.
- S  output  WIDTH  registered sum bits.
- Ca  output  1  registered carry-out.
- out_valid  output  1  S/Ca hold a fresh result.

Behaviour:
- Reset:
  - rst high forces S=0, Ca=0, out_valid=0 immediately, without waiting for clk.
  - Outputs stay at these values while rst is high.
  - First capture is the first rising clk edge after rst deasserts.
- Per-bit cell, bit i:
  - s[i] = a[i] ^ b[i] ^ c[i].
  - c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])).
  - c[0] = C.
- Word result:
  - {Ca,S} = A + B + C, computed at WIDTH+1 bits with no truncation.
  - Ca = c[WIDTH].
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear on S/Ca after edge N, with out_valid=1.
- Hold: in_valid=0 at an edge means S/Ca keep their previous values and out_valid goes to 0 for that cycle.
- Throughput: one result per cycle; back-to-back in_valid is allowed with no bubbles.
- Unknown inputs: X/Z on A/B/C while in_valid=1 is a caller error. Nothing is defined for it and nothing checks for it.
- Reset mid-operation: rst asserted between capture and output discards the in-flight result. Outputs read 0 and out_valid=0; no stale result appears after reset release.
- Boundary values:
  - Max operands, e.g. A=B=all-ones with C=1, give S=all-ones and Ca=1.
  - All-zero operands with C=0 give S=0 and Ca=0.
- No internal state beyond the output register and out_valid flop.
- The combinational ripple path is the critical path.

Optional Feature:
- Macro: FULLADDER_OVF_EN.
- With the macro defined:
  - Adds output port ovf, 1 bit, registered alongside S.
  - ovf = c[WIDTH] ^ c[WIDTH-1], the two's-complement signed overflow.
  - For WIDTH=1, ovf = Ca ^ C.
  - ovf resets to 0 asynchronously with the other outputs and holds when in_valid=0.
- Without the macro: the ovf port and its flop do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with S=1, Ca=1 → S=0, Ca=0, out_valid=0 immediately, before the next clk edge.
- WIDTH=1 exhaustive: drive A,B,C through 000,001,010,011,100,101,110,111 on consecutive cycles with in_valid=1 → one cycle later each, {Ca,S} equals 00,01,01,10,01,10,10,11 in that order; out_valid=1 throughout.
- Hold: in_valid=0 after A=1,B=1,C=0 → S=0, Ca=1 persist, out_valid=0.
- WIDTH=8 boundary:
  - A=8'hFF, B=8'hFF, C=1 → S=8'hFF, Ca=1.
  - A=8'h80, B=8'h80, C=0 → S=8'h00, Ca=1; with FULLADDER_OVF_EN, ovf=1.
- Reset in flight: capture A=1,B=1,C=1, assert rst before the next edge, release → S=0, Ca=0, out_valid=0 until a new in_valid capture.
- WIDTH=8 random: 1000 random A/B/C with random in_valid → every out_valid result matches the reference A+B+C at 9 bits, one cycle later.
